codec_dac_tx: RTL

- Playback-side serializer for the audio codec: the transmit counterpart of the codec capture path.
- Accepts stereo sample pairs from the processing logic through a valid/ready handshake and buffers them in a small FIFO.
- Shifts the samples out MSB-first in I2S format on the codec DAC data pin.
- The codec is bit-clock and frame-clock master: BCLK and DACLRCK are inputs, sampled in the clk domain.

---
 rtl/codec_dac_tx.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/codec_dac_tx.sv
// ---------------------------------------------------------------------------
// codec_dac_tx
//
// Playback-side I2S serializer for the audio codec DAC. Stereo sample pairs
// arrive from the processing logic over a valid/ready handshake. They are
// queued in a small circular FIFO and shifted out MSB-first on the DAC data
// pin. The codec is the bit-clock and frame-clock master, so BCLK and DACLRCK
// are asynchronous inputs. Both are synchronised into the clk domain, and
// every serial action is taken on the clk cycle that sees a BCLK falling edge.
//
// Optional feature (compile-time macro DAC_TX_HOLD_LAST_EN):
//   When defined, an underrun replays the last successfully popped pair.
//   When undefined, an underrun sends a zero pair.
//
// Ports:
//   clk                  system clock, must be at least 8x BCLK
//   rst                  synchronous active-high reset
//   codec_aud_bclk_i     codec bit clock (asynchronous)
//   codec_aud_daclrck_i  codec DAC frame clock (asynchronous), 0 = left
//   codec_aud_dacdat_o   serial DAC data to the codec
//   tx_left_i            left sample, two's complement
//   tx_right_i           right sample, two's complement
//   tx_valid_i           sample pair valid
//   tx_ready_o           FIFO can accept a pair
//   tx_level_o           registered FIFO occupancy in pairs
//   tx_underrun_o        sticky: a left slot started with the FIFO empty
//   tx_underrun_clr_i    clears tx_underrun_o (a new underrun wins)
// ---------------------------------------------------------------------------
module codec_dac_tx #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       codec_aud_bclk_i,
    input  logic                       codec_aud_daclrck_i,
    output logic                       codec_aud_dacdat_o,
    input  logic [DATA_WIDTH-1:0]      tx_left_i,
    input  logic [DATA_WIDTH-1:0]      tx_right_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic [FIFO_DEPTH_LOG2:0]   tx_level_o,
    output logic                       tx_underrun_o,
    input  logic                       tx_underrun_clr_i
);

    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W      = FIFO_DEPTH_LOG2;
    localparam int LVL_W      = FIFO_DEPTH_LOG2 + 1;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DELAY_L,
        SHIFT,
        PAD
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronisers and edge detection
    // -----------------------------------------------------------------------
    logic bclk_s1, bclk_s2, bclk_s3;
    logic lrck_s1, lrck_s2;
    logic lrck_prev;
    logic bclk_fe;
    logic lrck_edge;
    logic left_start;
    logic right_start;

    // Two flops per codec clock for metastability. A third BCLK flop gives
    // the falling-edge detector. lrck_prev records the frame clock as seen on
    // the last BCLK falling edge, so a slot change is only recognised on a
    // falling edge. It resets to 0 so that a reset taken in the middle of a
    // left slot cannot start a partial frame; a full 1 -> 0 change is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            bclk_s3   <= 1'b0;
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_s1 <= codec_aud_bclk_i;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lrck_s1 <= codec_aud_daclrck_i;
            lrck_s2 <= lrck_s1;
            if (bclk_fe) begin
                lrck_prev <= lrck_s2;
            end
        end
    end

    assign bclk_fe     = bclk_s3 & ~bclk_s2;
    assign lrck_edge   = bclk_fe & (lrck_s2 != lrck_prev);
    assign left_start  = lrck_edge & ~lrck_s2;
    assign right_start = lrck_edge & lrck_s2;

    // -----------------------------------------------------------------------
    // Sample FIFO
    // -----------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        level;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    underrun_evt;
    logic [DATA_WIDTH-1:0]   pop_left;
    logic [DATA_WIDTH-1:0]   pop_right;

    assign fifo_empty   = (level == '0);
    assign fifo_full    = (level == FULL_LEVEL);
    // Ready is held low while reset is asserted, even if the old level was
    // below full, so no pair is accepted into a FIFO that is being cleared.
    assign tx_ready_o   = ~rst & ~fifo_full;
    assign push         = tx_valid_i & tx_ready_o;
    // Pops use the registered level only, so a pair pushed in the same cycle
    // into an empty FIFO is not visible yet. That slot is an underrun.
    assign pop          = left_start & ~fifo_empty;
    assign underrun_evt = left_start & fifo_empty;
    assign pop_left     = fifo_mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
    assign pop_right    = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign tx_level_o   = level;

    // Storage has no reset; only the pointers and the level define content.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {tx_left_i, tx_right_i};
        end
    end

    // Pointers wrap naturally at the power-of-two depth. A push and a pop in
    // the same cycle leave the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Underrun fill data
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fill_left;
    logic [DATA_WIDTH-1:0] fill_right;

`ifdef DAC_TX_HOLD_LAST_EN
    logic [DATA_WIDTH-1:0] last_left;
    logic [DATA_WIDTH-1:0] last_right;

    // Remember the most recent popped pair so an underrun can replay it
    // instead of dropping to silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_left  <= '0;
            last_right <= '0;
        end else if (pop) begin
            last_left  <= pop_left;
            last_right <= pop_right;
        end
    end

    assign fill_left  = last_left;
    assign fill_right = last_right;
`else
    assign fill_left  = '0;
    assign fill_right = '0;
`endif

    // -----------------------------------------------------------------------
    // Sticky underrun flag
    // -----------------------------------------------------------------------

    // A new underrun wins over a clear in the same cycle, so an event is
    // never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_underrun_o <= 1'b0;
        end else if (underrun_evt) begin
            tx_underrun_o <= 1'b1;
        end else if (tx_underrun_clr_i) begin
            tx_underrun_o <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer FSM
    // -----------------------------------------------------------------------
    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] hold_next;
    logic [CNT_W-1:0]      bitcnt;
    logic [CNT_W-1:0]      bitcnt_next;
    logic [CNT_W-1:0]      bitcnt_inc;
    logic                  dacdat_r;
    logic                  dacdat_next;

    assign bitcnt_inc         = bitcnt + CNT_W'(1);
    assign codec_aud_dacdat_o = dacdat_r;

    // State and datapath registers. The data pin is registered, so reset
    // forces it low on the cycle after rst is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            hold_r   <= '0;
            bitcnt   <= '0;
            dacdat_r <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            hold_r   <= hold_next;
            bitcnt   <= bitcnt_next;
            dacdat_r <= dacdat_next;
        end
    end

    // Next-state logic. It only acts on BCLK falling edges. A frame-clock
    // change always takes priority over the current state. This cuts a word
    // short if the slot was shorter than DATA_WIDTH bits. The edge that starts
    // a slot drives the I2S one-bit delay (a 0). The MSB follows on the next
    // falling edge. Both DELAY_L and SHIFT shift out a bit on a plain edge.
    // The difference is that DELAY_L marks the left delay slot just sent.
    // A change to the right slot is ignored in IDLE. Playback starts only
    // from a left slot, so no half frame is ever emitted.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        hold_next   = hold_r;
        bitcnt_next = bitcnt;
        dacdat_next = dacdat_r;

        if (bclk_fe) begin
            dacdat_next = 1'b0;
            if (left_start) begin
                state_next  = DELAY_L;
                bitcnt_next = '0;
                if (fifo_empty) begin
                    shreg_next = fill_left;
                    hold_next  = fill_right;
                end else begin
                    shreg_next = pop_left;
                    hold_next  = pop_right;
                end
            end else if (right_start && (state != IDLE)) begin
                state_next  = SHIFT;
                shreg_next  = hold_r;
                bitcnt_next = '0;
            end else begin
                case (state)
                    DELAY_L, SHIFT: begin
                        dacdat_next = shreg[DATA_WIDTH-1];
                        shreg_next  = shreg << 1;
                        bitcnt_next = bitcnt_inc;
                        if (bitcnt_inc == LAST_BIT) begin
                            state_next = PAD;
                        end else begin
                            state_next = SHIFT;
                        end
                    end
                    default: begin
                        dacdat_next = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
